// File: rtl/sram_mp_ctrl_if.sv
// Client-side request bus of the multi-port SRAM controller: one
// req/we/be/addr/wdata slot per channel, a one-hot ack and shared read data.
interface sram_mp_ctrl_if #(
   parameter int unsigned NCH = 2,
   parameter int unsigned AW  = 17,
   parameter int unsigned DW  = 16
) ();
   localparam int unsigned BW = DW / 8;

   logic [NCH-1:0]    req;
   logic [NCH-1:0]    we;
   logic [NCH*BW-1:0] be;
   logic [NCH*AW-1:0] addr;
   logic [NCH*DW-1:0] wdata;
   logic [NCH-1:0]    ack;
   logic [DW-1:0]     rdata;

   modport master (output req, we, be, addr, wdata, input  ack, rdata);
   modport slave  (input  req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_mp_ctrl.sv
// Multi-port asynchronous SRAM controller. Wipes the whole array to WIPE_VAL
// after reset (or on request), then serves client channels one at a time
// through a round-robin arbiter. Every SRAM pin comes straight from a flop.
module sram_mp_ctrl #(
   parameter int unsigned   AW       = 17,
   parameter int unsigned   DW       = 16,
   parameter int unsigned   NCH      = 2,
   parameter int unsigned   RD_WAIT  = 1,
   parameter logic [DW-1:0] WIPE_VAL = '0
) (
   input  logic            clk,
   input  logic            reset,
   sram_mp_ctrl_if.slave   bus,
   input  logic            wipe_start_i,
   output logic            wipe_done_o,
   output logic [AW-1:0]   sram_addr_o,
   output logic [DW-1:0]   sram_dq_o,
   output logic            sram_dq_oe_o,
   input  logic [DW-1:0]   sram_dq_i,
   output logic            sram_we_n_o,
   output logic            sram_oe_n_o,
   output logic [DW/8-1:0] sram_be_n_o
);
   localparam int unsigned BW = DW / 8;
   localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {
      S_WIPE_WR,
      S_WIPE_GAP,
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   wcnt_q;
   logic [2:0]      wait_q;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   gnt_q;
   logic            lat_we_q;
   logic [NCH-1:0]  ack_q;
   logic [DW-1:0]   rdata_q;
   logic            wipe_done_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   dq_q;
   logic            dq_oe_q;
   logic            we_n_q;
   logic            oe_n_q;
   logic [BW-1:0]   be_n_q;

   // Per-channel views of the packed client buses.
   logic [BW-1:0]   be_arr    [NCH];
   logic [AW-1:0]   addr_arr  [NCH];
   logic [DW-1:0]   wdata_arr [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign be_arr[g]    = bus.be[g*BW +: BW];
      assign addr_arr[g]  = bus.addr[g*AW +: AW];
      assign wdata_arr[g] = bus.wdata[g*DW +: DW];
   end

   logic [NCH-1:0]  eff_req;
   logic            gnt_vld;
   logic [PW-1:0]   gnt_d;
   logic [PW-1:0]   idx;

   // Round-robin pick starting after the last grant. The channel being acked
   // this cycle still shows req high, so it is masked to avoid a double serve.
   always_comb begin
      eff_req = bus.req & ~ack_q;
      gnt_vld = 1'b0;
      gnt_d   = ptr_q;
      idx     = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         idx = PW'((32'(ptr_q) + i) % NCH);
         if (!gnt_vld && eff_req[idx]) begin
            gnt_vld = 1'b1;
            gnt_d   = idx;
         end
      end
   end

   // Controller FSM; pin registers double as the latched request fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_WIPE_WR;
         wcnt_q      <= '0;
         wait_q      <= '0;
         ptr_q       <= PW'(NCH - 1);
         gnt_q       <= '0;
         lat_we_q    <= 1'b0;
         ack_q       <= '0;
         rdata_q     <= '0;
         wipe_done_q <= 1'b0;
         addr_q      <= '0;
         dq_q        <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         be_n_q      <= '1;
      end else begin
         ack_q <= '0;
         case (state_q)
            S_WIPE_WR: begin
               addr_q  <= wcnt_q;
               dq_q    <= WIPE_VAL;
               dq_oe_q <= 1'b1;
               we_n_q  <= 1'b0;
               oe_n_q  <= 1'b1;
               be_n_q  <= '0;
               state_q <= S_WIPE_GAP;
            end
            S_WIPE_GAP: begin
               we_n_q <= 1'b1;
               wcnt_q <= wcnt_q + 1'b1;
               if (wcnt_q == '1) begin
                  dq_oe_q     <= 1'b0;
                  be_n_q      <= '1;
                  wipe_done_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  state_q <= S_WIPE_WR;
               end
            end
            S_IDLE: begin
               we_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               be_n_q  <= '1;
               dq_oe_q <= 1'b0;
               if (wipe_start_i) begin
                  wcnt_q      <= '0;
                  wipe_done_q <= 1'b0;
                  state_q     <= S_WIPE_WR;
               end else if (gnt_vld) begin
                  ptr_q    <= gnt_d;
                  gnt_q    <= gnt_d;
                  lat_we_q <= bus.we[gnt_d];
                  wait_q   <= 3'(RD_WAIT);
                  addr_q   <= addr_arr[gnt_d];
                  be_n_q   <= ~be_arr[gnt_d];
                  if (bus.we[gnt_d]) begin
                     we_n_q  <= 1'b0;
                     dq_oe_q <= 1'b1;
                     dq_q    <= wdata_arr[gnt_d];
                  end else begin
                     oe_n_q <= 1'b0;
                  end
                  state_q <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (wait_q == '0) begin
                  if (!lat_we_q) begin
                     rdata_q <= sram_dq_i;
                  end
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  be_n_q  <= '1;
                  dq_oe_q <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  wait_q <= wait_q - 1'b1;
               end
            end
            S_DONE: begin
               ack_q[gnt_q] <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ack      = ack_q;
   assign bus.rdata    = rdata_q;
   assign wipe_done_o  = wipe_done_q;
   assign sram_addr_o  = addr_q;
   assign sram_dq_o    = dq_q;
   assign sram_dq_oe_o = dq_oe_q;
   assign sram_we_n_o  = we_n_q;
   assign sram_oe_n_o  = oe_n_q;
   assign sram_be_n_o  = be_n_q;
endmodule

// File: tb/tb_sram_mp_ctrl.sv
// Directed + randomized bench for sram_mp_ctrl with a behavioural SRAM and a
// word-array reference model of what the memory should hold.
module tb_sram_mp_ctrl;
   localparam int unsigned AW      = 4;
   localparam int unsigned DW      = 16;
   localparam int unsigned NCH     = 2;
   localparam int unsigned RD_WAIT = 1;
   localparam int unsigned BW      = DW / 8;
   localparam logic [DW-1:0] WIPE  = 16'hA5C3;
   localparam int unsigned DEPTH   = 2 ** AW;
   // negedge samples from driving req until ack is visible: req is taken on
   // the first edge and ack rises 2+RD_WAIT edges after that
   localparam int LAT = 3 + RD_WAIT;

   logic          clk = 1'b0;
   logic          reset;
   logic          wipe_start;
   logic          wipe_done;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_dq_o;
   logic          sram_dq_oe;
   logic [DW-1:0] sram_dq_i;
   logic          sram_we_n;
   logic          sram_oe_n;
   logic [BW-1:0] sram_be_n;

   sram_mp_ctrl_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

   sram_mp_ctrl #(
      .AW(AW), .DW(DW), .NCH(NCH), .RD_WAIT(RD_WAIT), .WIPE_VAL(WIPE)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .wipe_start_i(wipe_start), .wipe_done_o(wipe_done),
      .sram_addr_o(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe_o(sram_dq_oe),
      .sram_dq_i(sram_dq_i), .sram_we_n_o(sram_we_n), .sram_oe_n_o(sram_oe_n),
      .sram_be_n_o(sram_be_n)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM (sampled on the clock for simplicity).
   logic [DW-1:0] mem [DEPTH];
   assign sram_dq_i = (sram_oe_n === 1'b0) ? mem[sram_addr] : 16'h5A5A;
   always @(posedge clk) begin
      if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1)
         for (int b = 0; b < int'(BW); b++)
            if (!sram_be_n[b]) mem[sram_addr][b*8 +: 8] <= sram_dq_o[b*8 +: 8];
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [DEPTH];
   int            last_gnt;
   int            n_pass = 0;
   int            n_tot  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [BW-1:0] be);
      logic [DW-1:0] r = old_w;
      for (int b = 0; b < int'(BW); b++)
         if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   function automatic int rr_pick(input int last, input logic [NCH-1:0] pend);
      for (int i = 1; i <= int'(NCH); i++)
         if (pend[(last + i) % NCH]) return (last + i) % NCH;
      return -1;
   endfunction

   // Follows a wipe from the current negedge until wipe_done rises.
   task automatic wait_wipe(input string tag);
      int cyc = 0;
      int pulses = 0;
      while (wipe_done === 1'b0 && cyc < 200) begin
         check({tag, "_no_ack"}, 32'(bus.ack), 0);
         if (sram_we_n === 1'b0) begin
            check({tag, "_addr"}, 32'(sram_addr), pulses);
            check({tag, "_data"}, 32'(sram_dq_o), 32'(WIPE));
            check({tag, "_be_n"}, 32'(sram_be_n), 0);
            pulses++;
         end
         cyc++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, cyc, 2 * DEPTH);
      check({tag, "_pulses"}, pulses, DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = WIPE;
   endtask

   task automatic wait_ack(output int ch, output int cyc);
      ch  = -1;
      cyc = 0;
      while (ch < 0 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         check("ack_onehot", 32'($onehot0(bus.ack)), 1);
         for (int i = 0; i < int'(NCH); i++) if (bus.ack[i]) ch = i;
      end
      check("ack_seen", 32'(ch >= 0), 1);
   endtask

   task automatic drive(input int ch, input bit w, input logic [BW-1:0] be,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we[ch]              = w;
      bus.be[ch*BW +: BW]     = be;
      bus.addr[ch*AW +: AW]   = a;
      bus.wdata[ch*DW +: DW]  = d;
      bus.req[ch]             = 1'b1;
   endtask

   // One complete transaction from an idle controller, checked on the model.
   task automatic op(input string tag, input int ch, input bit w,
                     input logic [BW-1:0] be, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
      int gc, cyc;
      drive(ch, w, be, a, d);
      wait_ack(gc, cyc);
      check({tag, "_ch"}, gc, ch);
      check({tag, "_lat"}, cyc, LAT);
      if (w) ref_mem[a] = merge(ref_mem[a], d, be);
      else   check({tag, "_rdata"}, 32'(bus.rdata), 32'(ref_mem[a]));
      last_gnt = ch;
      bus.req[ch] = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_idle_pins(input string tag);
      check({tag, "_we_n"}, 32'(sram_we_n), 1);
      check({tag, "_oe_n"}, 32'(sram_oe_n), 1);
      check({tag, "_dq_oe"}, 32'(sram_dq_oe), 0);
      check({tag, "_be_n"}, 32'(sram_be_n), 32'((1 << BW) - 1));
   endtask

   // Both channels request together; grants must alternate round-robin.
   task automatic dual_round(input string tag, input logic [AW-1:0] base);
      logic [NCH-1:0] pend;
      logic [DW-1:0]  d [NCH];
      int gc, cyc;
      for (int c = 0; c < int'(NCH); c++) begin
         d[c] = DW'($urandom);
         drive(c, 1'b1, '1, base + AW'(c), d[c]);
      end
      pend = '1;
      for (int k = 0; k < int'(NCH); k++) begin
         wait_ack(gc, cyc);
         check({tag, "_grant"}, gc, rr_pick(last_gnt, pend));
         if (gc >= 0) begin
            ref_mem[base + AW'(gc)] = d[gc];
            last_gnt = gc;
            pend[gc] = 1'b0;
            bus.req[gc] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int gc, cyc;
      logic [AW-1:0] a;
      reset = 1'b1;
      wipe_start = 1'b0;
      bus.req = '0; bus.we = '0; bus.be = '0; bus.addr = '0; bus.wdata = '0;
      last_gnt = NCH - 1;
      repeat (2) @(negedge clk);

      check_idle_pins("rst");
      check("rst_addr", 32'(sram_addr), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_rdata", 32'(bus.rdata), 0);
      check("rst_wipe_done", 32'(wipe_done), 0);

      reset = 1'b0;
      wait_wipe("wipe0");
      check_idle_pins("idle");

      op("wr_beef", 0, 1'b1, 2'b11, 4'h5, 16'hBEEF);
      op("rd_beef", 0, 1'b0, 2'b11, 4'h5, 16'h0);
      check("rd_beef_val", 32'(bus.rdata), 32'h0000BEEF);
      op("wr_lo", 0, 1'b1, 2'b01, 4'h5, 16'h1234);
      op("rd_lo", 0, 1'b0, 2'b11, 4'h5, 16'h0);
      check("rd_lo_val", 32'(bus.rdata), 32'h0000BE34);
      op("wr_be0", 1, 1'b1, 2'b00, 4'h5, 16'hFFFF);
      check("rdata_hold", 32'(bus.rdata), 32'h0000BE34);
      op("rd_be0", 1, 1'b0, 2'b11, 4'h5, 16'h0);

      for (int r = 0; r < 3; r++) dual_round("rr", 4'h8 + AW'(2 * r));
      op("rd_rr", 1, 1'b0, 2'b11, 4'h9, 16'h0);

      // Re-wipe requested in IDLE while ch1 already wants a read.
      drive(1, 1'b0, 2'b11, 4'h8, 16'h0);
      wipe_start = 1'b1;
      @(negedge clk);
      wipe_start = 1'b0;
      wait_wipe("wipe1");
      wait_ack(gc, cyc);
      check("postwipe_ch", gc, 1);
      check("postwipe_lat", cyc, LAT);
      check("postwipe_rdata", 32'(bus.rdata), 32'(WIPE));
      last_gnt = 1;
      bus.req[1] = 1'b0;
      @(negedge clk);
      a = AW'($urandom_range(0, DEPTH - 1));
      op("rd_wiped", 0, 1'b0, 2'b11, a, 16'h0);

      // wipe_start while an access is in flight has no effect.
      drive(0, 1'b1, 2'b11, 4'h3, 16'hC0DE);
      @(negedge clk);
      wipe_start = 1'b1;
      @(negedge clk);
      wipe_start = 1'b0;
      wait_ack(gc, cyc);
      check("busy_wipe_ch", gc, 0);
      check("busy_wipe_lat", cyc, LAT - 2);
      check("busy_wipe_done", 32'(wipe_done), 1);
      ref_mem[3] = 16'hC0DE;
      last_gnt = 0;
      bus.req[0] = 1'b0;
      @(negedge clk);
      op("rd_busy", 1, 1'b0, 2'b11, 4'h3, 16'h0);

      for (int n = 0; n < 30; n++)
         op("rand", $urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)),
            BW'($urandom_range(0, (1 << BW) - 1)),
            AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));

      // Reset in the second ACCESS cycle of a write aborts it cleanly.
      drive(0, 1'b1, 2'b11, 4'h7, 16'h7777);
      repeat (2) @(negedge clk);
      check("pre_rst_we_n", 32'(sram_we_n), 0);
      reset = 1'b1;
      #1;
      check_idle_pins("midrst");
      check("midrst_addr", 32'(sram_addr), 0);
      check("midrst_ack", 32'(bus.ack), 0);
      check("midrst_wipe_done", 32'(wipe_done), 0);
      bus.req = '0;
      @(negedge clk);
      check("midrst_ack2", 32'(bus.ack), 0);
      reset = 1'b0;
      last_gnt = NCH - 1;
      wait_wipe("wipe2");
      dual_round("rr_rst", 4'hC);
      op("rd_rst", 0, 1'b0, 2'b11, 4'h7, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end
endmodule
